// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module : pci_pkg
// Brief  : Shared state encoding and C/BE# constants for the PCI master agent.
// Rev    : 1.0
// ============================================================================
package pci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_TURN = 3'd4
  } pci_state_e;

  localparam logic [3:0] C_MEM_READ  = 4'b0110;
  localparam logic [3:0] C_MEM_WRITE = 4'b0111;
  localparam logic [3:0] C_CBE_ALL   = 4'b0000;
  localparam logic [3:0] C_CBE_IDLE  = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/pci_devsel_timer.sv
`default_nettype none
// ============================================================================
// Module : pci_devsel_timer
// Brief  : Counts unclaimed data cycles; flags the cycle that reaches the limit.
// Rev    : 1.0
// ============================================================================
module pci_devsel_timer #(
  parameter int DEVSEL_TO = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  // Only values up to DEVSEL_TO-1 are ever stored; the final step is the timeout.
  localparam int C_CNT_W = (DEVSEL_TO < 2) ? 1 : $clog2(DEVSEL_TO);

  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout = en && (r_cnt == C_CNT_W'(DEVSEL_TO - 1));

endmodule
`default_nettype wire

// File: rtl/pci_master_agent.sv
`default_nettype none
// ============================================================================
// Module : pci_master_agent
// Brief  : PCI-style initiator: request/grant, address phase, burst data, abort.
// Rev    : 1.0
// ============================================================================
module pci_master_agent
  import pci_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 4,
  parameter int DEVSEL_TO = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [ADDR_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              req_o,
  input  logic              gnt_i,
  input  logic              frame_n_i,
  input  logic              irdy_n_i,
  input  logic              trdy_n_i,
  input  logic              devsel_n_i,
  output logic              frame_n_o,
  output logic              irdy_n_o,
  output logic [ADDR_W-1:0] ad_o,
  input  logic [ADDR_W-1:0] ad_i,
  output logic [3:0]        cbe_n_o,
  output logic              ad_oe,
  output logic              ctl_oe
);

  pci_state_e        r_state;
  pci_state_e        w_state_nxt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_claimed;
  logic              r_abort;
  logic              r_err;
  logic [ADDR_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              w_beat;
  logic              w_last;
  logic              w_timeout;
  logic              w_tmr_en;

  assign w_last   = (r_remaining == LEN_W'(1));
  assign w_beat   = (r_state == ST_DATA) && !r_abort && !trdy_n_i && !devsel_n_i;
  // Once any target has claimed the cycle, wait states are unbounded.
  assign w_tmr_en = (r_state == ST_DATA) && !r_claimed && !r_abort && devsel_n_i;

  pci_devsel_timer #(
    .DEVSEL_TO (DEVSEL_TO)
  ) u_devsel_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (r_state == ST_ADDR),
    .en      (w_tmr_en),
    .timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    req_o       = 1'b0;
    frame_n_o   = 1'b1;
    irdy_n_o    = 1'b1;
    ad_oe       = 1'b0;
    ctl_oe      = 1'b0;
    ad_o        = '0;
    cbe_n_o     = C_CBE_IDLE;
    wdata_ack   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_ready   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        req_o = 1'b1;
        if (gnt_i && frame_n_i && irdy_n_i) begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ctl_oe      = 1'b1;
        ad_oe       = 1'b1;
        frame_n_o   = 1'b0;
        ad_o        = r_addr;
        cbe_n_o     = r_write ? C_MEM_WRITE : C_MEM_READ;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        ctl_oe    = 1'b1;
        irdy_n_o  = 1'b0;
        cbe_n_o   = C_CBE_ALL;
        // FRAME# rises on the final beat, or for the single abort-signalling cycle.
        frame_n_o = r_abort || w_last;
        if (r_write) begin
          ad_oe = 1'b1;
          ad_o  = wdata;
        end
        wdata_ack = w_beat && r_write;
        if (r_abort || (w_beat && w_last)) begin
          w_state_nxt = ST_TURN;
        end
      end
      ST_TURN: begin
        ctl_oe      = 1'b1;
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_claimed     <= 1'b0;
      r_abort       <= 1'b0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_beat && !r_write;
      if (w_beat && !r_write) begin
        r_rdata <= ad_i;
      end
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_write     <= cmd_write;
            r_addr      <= cmd_addr;
            r_remaining <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            r_err       <= 1'b0;
          end
        end
        ST_ADDR: begin
          r_claimed <= 1'b0;
          r_abort   <= 1'b0;
        end
        ST_DATA: begin
          if (!devsel_n_i) begin
            r_claimed <= 1'b1;
          end
          if (w_timeout) begin
            r_abort <= 1'b1;
            r_err   <= 1'b1;
          end
          if (w_beat) begin
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;

endmodule
`default_nettype wire

// File: tb/tb_pci_master_agent.sv
`default_nettype none
// ============================================================================
// Module : tb_pci_master_agent
// Brief  : Directed self-checking bench for pci_master_agent.
// Rev    : 1.0
// ============================================================================
module tb_pci_master_agent;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wdata = '0;
  logic        wdata_ack;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic        frame_n_i = 1'b1;
  logic        irdy_n_i = 1'b1;
  logic        trdy_n_i = 1'b1;
  logic        devsel_n_i = 1'b1;
  logic        frame_n_o;
  logic        irdy_n_o;
  logic [31:0] ad_o;
  logic [31:0] ad_i = '0;
  logic [3:0]  cbe_n_o;
  logic        ad_oe;
  logic        ctl_oe;

  int tests = 0;
  int fails = 0;

  pci_master_agent #(
    .ADDR_W    (32),
    .LEN_W     (4),
    .DEVSEL_TO (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_ack   (wdata_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .frame_n_i   (frame_n_i),
    .irdy_n_i    (irdy_n_i),
    .trdy_n_i    (trdy_n_i),
    .devsel_n_i  (devsel_n_i),
    .frame_n_o   (frame_n_o),
    .irdy_n_o    (irdy_n_o),
    .ad_o        (ad_o),
    .ad_i        (ad_i),
    .cbe_n_o     (cbe_n_o),
    .ad_oe       (ad_oe),
    .ctl_oe      (ctl_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench 1ns into the ADDR cycle with an immediate grant.
  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len);
    tick(); cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    tick(); cmd_valid = 1'b0; gnt_i = 1'b1;
    tick(); gnt_i = 1'b0; #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    #1;
    tests++;
    if ({req_o, ctl_oe, ad_oe, frame_n_o, irdy_n_o, cbe_n_o} !== {5'b00011, 4'hF}) begin
      fails++; $display("FAIL reset_ctl: got %b expected %b", {req_o, ctl_oe, ad_oe, frame_n_o, irdy_n_o, cbe_n_o}, {5'b00011, 4'hF});
    end
    tests++;
    if ({ad_o, rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_data: got ad_o=%h rdata=%h expected 0", ad_o, rdata);
    end
    tests++;
    if ({cmd_ready, wdata_ack, rdata_valid, done, err} !== 5'b0) begin
      fails++; $display("FAIL reset_pulses: got %b expected 00000", {cmd_ready, wdata_ack, rdata_valid, done, err});
    end
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    tick(); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000_0040; cmd_len = 4'd1; wdata = 32'hCAFE_0001; #1;
    tests++;
    if ({cmd_ready, req_o} !== 2'b10) begin
      fails++; $display("FAIL wr_accept: got %b expected 10", {cmd_ready, req_o});
    end
    tick(); cmd_valid = 1'b0; #1;
    tests++;
    if ({req_o, ctl_oe} !== 2'b10) begin
      fails++; $display("FAIL wr_req1: got %b expected 10", {req_o, ctl_oe});
    end
    tick(); gnt_i = 1'b1; #1;
    tests++;
    if ({req_o, ctl_oe} !== 2'b10) begin
      fails++; $display("FAIL wr_req2: got %b expected 10", {req_o, ctl_oe});
    end
    tick(); gnt_i = 1'b0; #1;
    tests++;
    if ({req_o, ctl_oe, ad_oe, frame_n_o, irdy_n_o, cbe_n_o} !== {5'b01101, 4'b0111}) begin
      fails++; $display("FAIL wr_addr_ctl: got %b expected %b", {req_o, ctl_oe, ad_oe, frame_n_o, irdy_n_o, cbe_n_o}, {5'b01101, 4'b0111});
    end
    tests++;
    if (ad_o !== 32'h1000_0040) begin
      fails++; $display("FAIL wr_addr: got %h expected 10000040", ad_o);
    end
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0; #1;
    tests++;
    if ({wdata_ack, frame_n_o, irdy_n_o, ad_oe, cbe_n_o} !== {4'b1101, 4'b0000}) begin
      fails++; $display("FAIL wr_data_ctl: got %b expected %b", {wdata_ack, frame_n_o, irdy_n_o, ad_oe, cbe_n_o}, {4'b1101, 4'b0000});
    end
    tests++;
    if (ad_o !== 32'hCAFE_0001) begin
      fails++; $display("FAIL wr_data: got %h expected cafe0001", ad_o);
    end
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, err, ctl_oe, ad_oe, frame_n_o, irdy_n_o, wdata_ack} !== 7'b1010110) begin
      fails++; $display("FAIL wr_turn: got %b expected 1010110", {done, err, ctl_oe, ad_oe, frame_n_o, irdy_n_o, wdata_ack});
    end
    tick(); #1;
    tests++;
    if ({done, ctl_oe, req_o} !== 3'b000) begin
      fails++; $display("FAIL wr_idle: got %b expected 000", {done, ctl_oe, req_o});
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] dat [0:3];
    logic [0:5]  tp;
    logic [31:0] pdat;
    logic        pend;
    int          beat;
    int          nvalid;
    dat[0] = 32'hA0A0_0001; dat[1] = 32'hB1B1_0002; dat[2] = 32'hC2C2_0003; dat[3] = 32'hD3D3_0004;
    tp = 6'b001100;
    beat = 0; pend = 1'b0; pdat = '0; nvalid = 0;
    start_cmd(1'b0, 32'h2000_0000, 4'd4);
    tests++;
    if ({ad_oe, cbe_n_o, ad_o} !== {1'b1, 4'b0110, 32'h2000_0000}) begin
      fails++; $display("FAIL rd_addr: got oe=%b cbe=%b ad=%h expected 1 0110 20000000", ad_oe, cbe_n_o, ad_o);
    end
    for (int c = 0; c < 6; c++) begin
      tick(); devsel_n_i = 1'b0; trdy_n_i = tp[c]; ad_i = dat[beat]; #1;
      tests++;
      if ({frame_n_o, irdy_n_o, ad_oe} !== {(c == 5), 1'b0, 1'b0}) begin
        fails++; $display("FAIL rd_ctl cycle %0d: got %b expected %b", c, {frame_n_o, irdy_n_o, ad_oe}, {(c == 5), 1'b0, 1'b0});
      end
      tests++;
      if (rdata_valid !== pend || (pend && rdata !== pdat)) begin
        fails++; $display("FAIL rd_beat cycle %0d: got valid=%b data=%h expected valid=%b data=%h", c, rdata_valid, rdata, pend, pdat);
      end
      if (rdata_valid === 1'b1) nvalid++;
      pend = !tp[c];
      if (pend) begin
        pdat = dat[beat];
        if (beat < 3) beat++;
      end
    end
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; ad_i = '0; #1;
    tests++;
    if ({done, err, rdata_valid, rdata} !== {1'b1, 1'b0, 1'b1, dat[3]}) begin
      fails++; $display("FAIL rd_turn: got done=%b err=%b valid=%b data=%h expected 1 0 1 %h", done, err, rdata_valid, rdata, dat[3]);
    end
    if (rdata_valid === 1'b1) nvalid++;
    tests++;
    if (nvalid !== 4) begin
      fails++; $display("FAIL rd_count: got %0d expected 4", nvalid);
    end
  endtask

  task automatic test_bus_busy();
    tick(); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000_0010; cmd_len = 4'd1; wdata = 32'h5555_AAAA;
    for (int c = 0; c < 5; c++) begin
      tick(); cmd_valid = 1'b0; gnt_i = 1'b1;
      frame_n_i = (c < 3) ? 1'b0 : 1'b1; irdy_n_i = 1'b0; #1;
      tests++;
      if ({req_o, ctl_oe, ad_oe} !== 3'b100) begin
        fails++; $display("FAIL busy_hold cycle %0d: got %b expected 100", c, {req_o, ctl_oe, ad_oe});
      end
    end
    tick(); frame_n_i = 1'b1; irdy_n_i = 1'b1; #1;
    tests++;
    if ({req_o, ctl_oe} !== 2'b10) begin
      fails++; $display("FAIL busy_release: got %b expected 10", {req_o, ctl_oe});
    end
    tick(); gnt_i = 1'b0; #1;
    tests++;
    if ({ctl_oe, frame_n_o, ad_o} !== {1'b1, 1'b0, 32'h3000_0010}) begin
      fails++; $display("FAIL busy_addr: got ctl=%b frame=%b ad=%h expected 1 0 30000010", ctl_oe, frame_n_o, ad_o);
    end
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0; #1;
    tests++;
    if ({wdata_ack, ad_o} !== {1'b1, 32'h5555_AAAA}) begin
      fails++; $display("FAIL busy_beat: got ack=%b ad=%h expected 1 5555aaaa", wdata_ack, ad_o);
    end
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, err} !== 2'b10) begin
      fails++; $display("FAIL busy_done: got %b expected 10", {done, err});
    end
  endtask

  task automatic test_master_abort();
    start_cmd(1'b0, 32'h4000_0000, 4'd2);
    for (int c = 0; c < 4; c++) begin
      tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b0; #1;
      tests++;
      if ({frame_n_o, irdy_n_o, rdata_valid, done} !== 4'b0000) begin
        fails++; $display("FAIL abort_wait cycle %0d: got %b expected 0000", c, {frame_n_o, irdy_n_o, rdata_valid, done});
      end
    end
    tick(); #1;
    tests++;
    if ({frame_n_o, irdy_n_o, ctl_oe, done, rdata_valid, wdata_ack} !== 6'b101000) begin
      fails++; $display("FAIL abort_frame: got %b expected 101000", {frame_n_o, irdy_n_o, ctl_oe, done, rdata_valid, wdata_ack});
    end
    tick(); trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, err, ctl_oe, frame_n_o, irdy_n_o, rdata_valid} !== 6'b111110) begin
      fails++; $display("FAIL abort_turn: got %b expected 111110", {done, err, ctl_oe, frame_n_o, irdy_n_o, rdata_valid});
    end
    tick(); #1;
    tests++;
    if ({done, err, ctl_oe} !== 3'b000) begin
      fails++; $display("FAIL abort_idle: got %b expected 000", {done, err, ctl_oe});
    end
  endtask

  task automatic test_devsel_late();
    wdata = 32'h0BAD_F00D;
    start_cmd(1'b1, 32'h4800_0000, 4'd1);
    for (int c = 0; c < 3; c++) begin
      tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
      tests++;
      if ({wdata_ack, frame_n_o, done} !== 3'b010) begin
        fails++; $display("FAIL late_wait cycle %0d: got %b expected 010", c, {wdata_ack, frame_n_o, done});
      end
    end
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0; #1;
    tests++;
    if ({wdata_ack, frame_n_o, irdy_n_o} !== 3'b110) begin
      fails++; $display("FAIL late_claim: got %b expected 110", {wdata_ack, frame_n_o, irdy_n_o});
    end
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, err} !== 2'b10) begin
      fails++; $display("FAIL late_done: got %b expected 10", {done, err});
    end
  endtask

  task automatic test_reset_mid();
    wdata = 32'h1111_2222;
    start_cmd(1'b1, 32'h5000_0000, 4'd3);
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0; #1;
    tests++;
    if ({wdata_ack, frame_n_o} !== 2'b10) begin
      fails++; $display("FAIL rst_beat1: got %b expected 10", {wdata_ack, frame_n_o});
    end
    tick(); trdy_n_i = 1'b1; #1;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({req_o, ctl_oe, ad_oe, frame_n_o, irdy_n_o, cbe_n_o, ad_o} !== {5'b00011, 4'hF, 32'h0}) begin
      fails++; $display("FAIL rst_async: got %b %h expected 000111111 00000000", {req_o, ctl_oe, ad_oe, frame_n_o, irdy_n_o, cbe_n_o}, ad_o);
    end
    tick(); rst_n = 1'b1; devsel_n_i = 1'b1;
    tick(); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000_0000; cmd_len = 4'd1; wdata = 32'h3333_4444; #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rst_accept: got %b expected 1", cmd_ready);
    end
    tick(); cmd_valid = 1'b0; gnt_i = 1'b1;
    tick(); gnt_i = 1'b0; #1;
    tests++;
    if ({frame_n_o, ad_o} !== {1'b0, 32'h6000_0000}) begin
      fails++; $display("FAIL rst_addr: got frame=%b ad=%h expected 0 60000000", frame_n_o, ad_o);
    end
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0; #1;
    tests++;
    if ({wdata_ack, frame_n_o} !== 2'b11) begin
      fails++; $display("FAIL rst_beat: got %b expected 11", {wdata_ack, frame_n_o});
    end
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, err} !== 2'b10) begin
      fails++; $display("FAIL rst_done: got %b expected 10", {done, err});
    end
  endtask

  task automatic test_len_zero();
    start_cmd(1'b0, 32'h7000_0000, 4'd0);
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0; ad_i = 32'hDEAD_BEEF; #1;
    tests++;
    if ({frame_n_o, irdy_n_o} !== 2'b10) begin
      fails++; $display("FAIL len0_frame: got %b expected 10", {frame_n_o, irdy_n_o});
    end
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; ad_i = '0; #1;
    tests++;
    if ({done, err, rdata_valid, rdata} !== {3'b101, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL len0_turn: got done=%b err=%b valid=%b data=%h expected 1 0 1 deadbeef", done, err, rdata_valid, rdata);
    end
    tick(); #1;
    tests++;
    if ({rdata_valid, done, ctl_oe} !== 3'b000) begin
      fails++; $display("FAIL len0_idle: got %b expected 000", {rdata_valid, done, ctl_oe});
    end
  endtask

  task automatic test_back_to_back();
    tick(); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0100; cmd_len = 4'd1; wdata = 32'h0000_0001; #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_accept1: got %b expected 1", cmd_ready);
    end
    tick(); cmd_addr = 32'h9000_0200; gnt_i = 1'b1; #1;
    tests++;
    if ({cmd_ready, req_o} !== 2'b01) begin
      fails++; $display("FAIL b2b_ignore: got %b expected 01", {cmd_ready, req_o});
    end
    tick(); gnt_i = 1'b0; #1;
    tests++;
    if (ad_o !== 32'h8000_0100) begin
      fails++; $display("FAIL b2b_addr1: got %h expected 80000100", ad_o);
    end
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0;
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, cmd_ready} !== 2'b10) begin
      fails++; $display("FAIL b2b_turn: got %b expected 10", {done, cmd_ready});
    end
    tick(); #1;
    tests++;
    if ({cmd_ready, done} !== 2'b10) begin
      fails++; $display("FAIL b2b_accept2: got %b expected 10", {cmd_ready, done});
    end
    tick(); cmd_valid = 1'b0; gnt_i = 1'b1;
    tick(); gnt_i = 1'b0; #1;
    tests++;
    if (ad_o !== 32'h9000_0200) begin
      fails++; $display("FAIL b2b_addr2: got %h expected 90000200", ad_o);
    end
    tick(); devsel_n_i = 1'b0; trdy_n_i = 1'b0;
    tick(); devsel_n_i = 1'b1; trdy_n_i = 1'b1; #1;
    tests++;
    if ({done, err} !== 2'b10) begin
      fails++; $display("FAIL b2b_done2: got %b expected 10", {done, err});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_bus_busy();
    test_master_abort();
    test_devsel_late();
    test_reset_mid();
    test_len_zero();
    test_back_to_back();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
